// File: rtl/mult_share_ctrl.sv
// Round-robin sharing of one fixed-latency pipelined multiplier between
// NREQ requesters, with in-order tagged responses through a credit FIFO.
//
// Ports:
//   CLK, RST_n      clock (rising edge), asynchronous active-low reset
//   flush           synchronous abort of all outstanding work
//   req_valid/ready per-requester valid/ready, ready is one-hot or zero
//   req_a/req_b     packed operands, requester i at [i*NBIT +: NBIT]
//   mul_en/a/b      registered issue strobe and operands to multiplier
//   mul_p           product, sampled LAT cycles after mul_en
//   rsp_valid/ready response FIFO head handshake
//   rsp_id/rsp_p    requester index and signed product of the head
//   busy            any operation outstanding

module mult_share_ctrl #(
    parameter int NREQ  = 4,
    parameter int NBIT  = 11,
    parameter int LAT   = 2,
    parameter int DEPTH = 4,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic                 CLK,
    input  logic                 RST_n,
    input  logic                 flush,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*NBIT-1:0] req_a,
    input  logic [NREQ*NBIT-1:0] req_b,
    output logic                 mul_en,
    output logic [NBIT-1:0]      mul_a,
    output logic [NBIT-1:0]      mul_b,
    input  logic [2*NBIT-1:0]    mul_p,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [2*NBIT-1:0]    rsp_p,
    output logic                 busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(DEPTH + LAT + 2);
    localparam int EW = ID_W + 2 * NBIT;

    // Round-robin pointer and issue stage
    logic [ID_W-1:0]           ptr_q, ptr_d;
    logic                      mul_en_q, mul_en_d;
    logic [NBIT-1:0]           mul_a_q, mul_a_d;
    logic [NBIT-1:0]           mul_b_q, mul_b_d;
    logic [ID_W-1:0]           iss_id_q, iss_id_d;

    // Tag pipe aligned with the multiplier latency
    logic [LAT-1:0]            tag_v_q, tag_v_d;
    logic [LAT-1:0][ID_W-1:0]  tag_id_q, tag_id_d;

    // Response FIFO
    logic [EW-1:0]             mem_q [DEPTH];
    logic [PW-1:0]             wr_q, wr_d;
    logic [PW-1:0]             rd_q, rd_d;
    logic [CW-1:0]             cnt_q, cnt_d;

    logic [OW-1:0]             outst;
    logic                      credit;
    logic [ID_W-1:0]           cand;
    logic [ID_W-1:0]           gnt_id;
    logic                      gnt_found;
    logic                      hs;
    logic                      push;
    logic                      pop;
    logic                      fifo_nempty;
    logic [EW-1:0]             head;

    // Credits cover every stage an op can occupy, so the FIFO never
    // overflows; a pop only returns its credit on the following cycle
    // because outst is built from registered state.
    assign outst = OW'(mul_en_q)
                 + OW'($countones(tag_v_q))
                 + OW'(cnt_q);
    assign credit = (outst < OW'(DEPTH));

    always_comb begin
        cand      = '0;
        gnt_id    = '0;
        gnt_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = ID_W'((int'(ptr_q) + k) % NREQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_id    = cand;
            end
        end
    end

    // A found grant already implies req_valid of that requester
    assign hs = RST_n & ~flush & credit & gnt_found;

    always_comb begin
        req_ready = '0;
        if (hs) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    assign fifo_nempty = (cnt_q != '0);
    assign push        = tag_v_q[LAT-1];
    assign pop         = fifo_nempty & rsp_ready;

    always_comb begin
        ptr_d    = ptr_q;
        mul_en_d = hs;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        iss_id_d = iss_id_q;
        tag_v_d  = tag_v_q;
        tag_id_d = tag_id_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;

        if (hs) begin
            if (gnt_id == ID_W'(NREQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_id + ID_W'(1);
            end
            mul_a_d  = req_a[gnt_id*NBIT +: NBIT];
            mul_b_d  = req_b[gnt_id*NBIT +: NBIT];
            iss_id_d = gnt_id;
        end

        for (int k = LAT - 1; k > 0; k--) begin
            tag_v_d[k]  = tag_v_q[k-1];
            tag_id_d[k] = tag_id_q[k-1];
        end
        tag_v_d[0]  = mul_en_q;
        tag_id_d[0] = iss_id_q;

        if (push) begin
            if (wr_q == PW'(DEPTH - 1)) begin
                wr_d = '0;
            end else begin
                wr_d = wr_q + PW'(1);
            end
        end
        if (pop) begin
            if (rd_q == PW'(DEPTH - 1)) begin
                rd_d = '0;
            end else begin
                rd_d = rd_q + PW'(1);
            end
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - CW'(1);
        end

        // Flush overrides any same-cycle push, pop or issue; operands hold
        if (flush) begin
            ptr_d    = '0;
            mul_en_d = 1'b0;
            tag_v_d  = '0;
            wr_d     = '0;
            rd_d     = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            ptr_q    <= '0;
            mul_en_q <= 1'b0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            iss_id_q <= '0;
            tag_v_q  <= '0;
            tag_id_q <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
        end else begin
            ptr_q    <= ptr_d;
            mul_en_q <= mul_en_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            iss_id_q <= iss_id_d;
            tag_v_q  <= tag_v_d;
            tag_id_q <= tag_id_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the head is only exposed while count != 0
    always_ff @(posedge CLK) begin
        if (push && !flush) begin
            mem_q[wr_q] <= {tag_id_q[LAT-1], mul_p};
        end
    end

    assign head      = mem_q[rd_q];
    assign rsp_valid = fifo_nempty;
    assign rsp_id    = fifo_nempty ? head[EW-1 -: ID_W] : '0;
    assign rsp_p     = fifo_nempty ? head[2*NBIT-1:0] : '0;

    assign mul_en = mul_en_q;
    assign mul_a  = mul_a_q;
    assign mul_b  = mul_b_q;
    assign busy   = (outst != '0);

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Self-checking bench for mult_share_ctrl: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.

module tb_mult_share_ctrl;

    localparam int NREQ  = 4;
    localparam int NBIT  = 11;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int ID_W  = 2;

    logic                 CLK = 1'b0;
    logic                 RST_n;
    logic                 flush;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*NBIT-1:0] req_a;
    logic [NREQ*NBIT-1:0] req_b;
    logic                 mul_en;
    logic [NBIT-1:0]      mul_a;
    logic [NBIT-1:0]      mul_b;
    logic [2*NBIT-1:0]    mul_p;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [2*NBIT-1:0]    rsp_p;
    logic                 busy;

    always #5 CLK = ~CLK;

    mult_share_ctrl #(
        .NREQ  (NREQ),
        .NBIT  (NBIT),
        .LAT   (LAT),
        .DEPTH (DEPTH)
    ) dut (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_en    (mul_en),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .busy      (busy)
    );

    typedef struct {
        int          id;
        logic [21:0] p;
        int          rdy;
    } op_t;

    // Reference model: ops not yet popped, in issue order, each with the
    // first cycle it may appear at the response head.
    op_t             q[$];
    int              m_ptr;
    bit              m_en;
    logic [NBIT-1:0] m_a;
    logic [NBIT-1:0] m_b;

    // Behavioural multiplier driving mul_p
    logic            mv[LAT];
    logic [21:0]     mp[LAT];

    int          cyc;
    int          n_chk;
    int          n_fail;
    int          n_hs;
    int          n_rsp;
    int          hs_cyc;
    int          hs_id;
    int          last_id;
    int          last_cyc;
    logic [21:0] last_p;
    int          gq[$];
    int          rq[$];

    function automatic logic [21:0] prod(input logic signed [NBIT-1:0] a,
                                         input logic signed [NBIT-1:0] b);
        logic signed [21:0] r;
        r = a * b;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [NBIT-1:0] a,
                           input logic [NBIT-1:0] b);
        req_a[i*NBIT +: NBIT] = a;
        req_b[i*NBIT +: NBIT] = b;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, NBIT'($urandom), NBIT'($urandom));
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ptr = 0;
        m_en  = 1'b0;
        m_a   = '0;
        m_b   = '0;
    endtask

    // One clock cycle: drive mul_p, check all outputs, advance the model
    task automatic cycle();
        int              out;
        int              g;
        int              og;
        logic [NREQ-1:0] er;
        bit              ev;
        bit              pop;
        logic            cap_en;
        logic [21:0]     cap_p;
        @(negedge CLK);
        mul_p = mv[LAT-1] ? mp[LAT-1] : 22'($urandom);
        #1;
        out = q.size();
        g   = -1;
        er  = '0;
        if (RST_n && !flush && out < DEPTH) begin
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && req_valid[(m_ptr + k) % NREQ]) begin
                    g = (m_ptr + k) % NREQ;
                end
            end
        end
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", req_ready, er);
        chk("mul_en", mul_en, m_en);
        chk("mul_a", mul_a, m_a);
        chk("mul_b", mul_b, m_b);
        ev = (out > 0) && (q[0].rdy <= cyc);
        chk("rsp_valid", rsp_valid, ev);
        if (ev) begin
            chk("rsp_id", rsp_id, q[0].id);
            chk("rsp_p", rsp_p, q[0].p);
        end
        chk("busy", busy, out != 0);
        chk("no_full_push",
            dut.tag_v_q[LAT-1] && (dut.cnt_q == DEPTH), 0);
        pop = ev && rsp_ready;
        og  = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (req_ready[k] && req_valid[k]) og = k;
        end
        if (og >= 0) begin
            n_hs++;
            hs_cyc = cyc;
            hs_id  = og;
            gq.push_back(og);
        end
        if (rsp_valid && rsp_ready) begin
            n_rsp++;
            last_id  = int'(rsp_id);
            last_p   = rsp_p;
            last_cyc = cyc;
            rq.push_back(int'(rsp_id));
        end
        cap_en = mul_en;
        cap_p  = prod(mul_a, mul_b);
        @(posedge CLK);
        if (!RST_n) begin
            model_reset();
        end else if (flush) begin
            q.delete();
            m_ptr = 0;
            m_en  = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            m_en = (g >= 0);
            if (g >= 0) begin
                m_a = req_a[g*NBIT +: NBIT];
                m_b = req_b[g*NBIT +: NBIT];
                q.push_back('{g, prod(m_a, m_b), cyc + LAT + 2});
                m_ptr = (g + 1) % NREQ;
            end
        end
        for (int k = LAT - 1; k > 0; k--) begin
            mv[k] = mv[k-1];
            mp[k] = mp[k-1];
        end
        mv[0] = cap_en;
        mp[0] = cap_p;
        cyc++;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int rot_bad;
        int ord_bad;
        RST_n     = 1'b0;
        flush     = 1'b0;
        rsp_ready = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        mul_p     = '0;
        cyc       = 0;
        n_chk     = 0;
        n_fail    = 0;
        n_hs      = 0;
        n_rsp     = 0;
        hs_cyc    = 0;
        hs_id     = -1;
        last_id   = -1;
        last_cyc  = 0;
        last_p    = '0;
        for (int k = 0; k < LAT; k++) begin
            mv[k] = 1'b0;
            mp[k] = '0;
        end
        model_reset();

        // Reset state, with requests pending
        req_valid = '1;
        run(3);
        #2 RST_n = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        run(4);

        // Single op: req1, 3 * -5
        req_valid = 4'b0010;
        set_req(1, 11'd3, 11'h7FB);
        cycle();
        req_valid = '0;
        run(8);
        chk("single_id", last_id, 1);
        chk("single_p", last_p, 22'h3FFFF1);
        chk("single_lat", last_cyc - hs_cyc, LAT + 2);
        chk("single_busy", busy, 0);

        // Round robin with all requesters valid
        gq.delete();
        rq.delete();
        req_valid = '1;
        for (int i = 0; i < 30; i++) begin
            rand_ops();
            cycle();
        end
        req_valid = '0;
        run(8);
        rot_bad = 0;
        ord_bad = 0;
        for (int i = 1; i < gq.size(); i++) begin
            if (gq[i] != (gq[i-1] + 1) % NREQ) rot_bad++;
        end
        for (int i = 0; i < rq.size() && i < gq.size(); i++) begin
            if (rq[i] != gq[i]) ord_bad++;
        end
        chk("rr_rotation", rot_bad, 0);
        chk("rr_order", ord_bad, 0);
        chk("rr_count", rq.size(), gq.size());
        chk("rr_volume", gq.size() >= 16, 1);

        // Backpressure: only DEPTH credits
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        n_hs      = 0;
        run(10);
        chk("bp_hs_full", n_hs, DEPTH);
        rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;
        run(5);
        chk("bp_hs_one_more", n_hs, DEPTH + 1);
        chk("bp_hs_delay", hs_cyc - last_cyc, 1);
        req_valid = '0;
        rsp_ready = 1'b1;
        run(10);

        // Operand extremes
        req_valid = 4'b0001;
        set_req(0, 11'h400, 11'h400);
        cycle();
        req_valid = '0;
        run(6);
        chk("ext_min_min", last_p, 22'h100000);
        req_valid = 4'b0100;
        set_req(2, 11'h3FF, 11'h400);
        cycle();
        req_valid = '0;
        run(6);
        chk("ext_max_min", last_p, 22'h300400);
        chk("ext_id", last_id, 2);

        // Flush with 3 in flight and 1 in the FIFO
        rsp_ready = 1'b0;
        req_valid = '1;
        rand_ops();
        run(4);
        chk("fl_pre_busy", busy, 1);
        flush = 1'b1;
        cycle();
        flush     = 1'b0;
        req_valid = '0;
        chk("fl_rsp_valid", rsp_valid, 0);
        chk("fl_busy", busy, 0);
        rsp_ready = 1'b1;
        n_rsp     = 0;
        run(6);
        chk("fl_discard", n_rsp, 0);
        req_valid = 4'b1000;
        set_req(3, 11'd100, 11'h7FF);
        cycle();
        req_valid = '0;
        run(6);
        chk("fl_new_id", last_id, 3);
        chk("fl_new_p", last_p, 22'h3FFF9C);
        chk("fl_new_cnt", n_rsp, 1);

        // Random traffic with occasional flushes
        for (int i = 0; i < 300; i++) begin
            req_valid = NREQ'($urandom);
            rand_ops();
            rsp_ready = ($urandom_range(3) != 0);
            flush     = ($urandom_range(39) == 0);
            cycle();
        end
        flush     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        run(10);
        chk("rnd_drained", busy, 0);

        // Asynchronous reset between edges with 4 outstanding
        rsp_ready = 1'b0;
        req_valid = '1;
        rand_ops();
        run(6);
        #2 RST_n = 1'b0;
        #1;
        model_reset();
        chk("ar_mul_en", mul_en, 0);
        chk("ar_mul_a", mul_a, 0);
        chk("ar_mul_b", mul_b, 0);
        chk("ar_rsp_valid", rsp_valid, 0);
        chk("ar_rsp_id", rsp_id, 0);
        chk("ar_rsp_p", rsp_p, 0);
        chk("ar_busy", busy, 0);
        chk("ar_req_ready", req_ready, 0);
        rsp_ready = 1'b1;
        n_rsp     = 0;
        run(2);
        #2 RST_n = 1'b1;
        req_valid = 4'b1010;
        hs_id     = -1;
        cycle();
        chk("ar_first_gnt", hs_id, 1);
        req_valid = '0;
        run(8);
        chk("ar_rsp_cnt", n_rsp, 1);
        chk("ar_rsp_id_post", last_id, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
